// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MCU51 program-memory fetch unit assembling 1-3 byte instructions
module instr_fetch #(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 rom_CS,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  input  logic                 jump_en,
  input  logic [ADDRWIDTH-1:0] jump_addr,
  input  logic                 instr_ready,
  output logic                 instr_valid,
  output logic [7:0]           opcode,
  output logic [7:0]           operand1,
  output logic [7:0]           operand2,
  output logic [1:0]           instr_len,
  output logic [ADDRWIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {F_OP, F_B1, F_B2, HOLD} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDRWIDTH-1:0]   pc;
  logic [ADDRWIDTH-1:0]   pc_inc;
  logic [1:0]             new_len;

  // 8051 instruction length derived from the opcode byte
  function automatic logic [1:0] len_of(input logic [7:0] op);
    logic [1:0] l;
    l = 2'd1;
    casez (op)
      8'h02, 8'h12, 8'h75, 8'h85, 8'h90: l = 2'd3;
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h44, 8'h45,
      8'h54, 8'h55, 8'h64, 8'h65, 8'h74, 8'h76, 8'h77,
      8'b0111_1???,
      8'h80, 8'h86, 8'h87,
      8'b1000_1???,
      8'h94, 8'h95, 8'hA6, 8'hA7,
      8'b1010_1???,
      8'hE5, 8'hF5:                      l = 2'd2;
      default:                           l = 2'd1;
    endcase
    return l;
  endfunction

  assign pc_inc   = pc + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  assign new_len  = len_of(rom_data);
  assign rom_addr = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_OP;
    else        state <= state_nxt;
  end

  // Next-state: a jump always restarts at the opcode fetch
  always_comb begin
    state_nxt = state;
    if (jump_en) begin
      state_nxt = F_OP;
    end else begin
      case (state)
        F_OP:    state_nxt = (new_len == 2'd1) ? HOLD : F_B1;
        F_B1:    state_nxt = (instr_len == 2'd3) ? F_B2 : HOLD;
        F_B2:    state_nxt = HOLD;
        HOLD:    state_nxt = instr_ready ? F_OP : HOLD;
        default: state_nxt = F_OP;
      endcase
    end
  end

  // Outputs decoded from state: ROM deselected and instruction presented while holding
  always_comb begin
    rom_CS      = (state == HOLD);
    instr_valid = (state == HOLD);
  end

  // Program counter and instruction field capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      opcode    <= 8'h00;
      operand1  <= 8'h00;
      operand2  <= 8'h00;
      instr_len <= 2'd1;
      instr_pc  <= '0;
    end else if (jump_en) begin
      pc <= jump_addr;
    end else begin
      case (state)
        F_OP: begin
          opcode    <= rom_data;
          instr_pc  <= pc;
          instr_len <= new_len;
          operand1  <= 8'h00;
          operand2  <= 8'h00;
          pc        <= pc_inc;
        end
        F_B1: begin
          operand1 <= rom_data;
          pc       <= pc_inc;
        end
        F_B2: begin
          operand2 <= rom_data;
          pc       <= pc_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       rom_CS;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       instr_ready;
  logic       instr_valid;
  logic [7:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;

  int tests;
  int fails;

  logic [7:0] rom [256];
  logic [7:0] rom_q;

  instr_fetch #(.ADDRWIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_CS      (rom_CS),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .operand1    (operand1),
    .operand2    (operand2),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registers on negedge, output gated by chip select
  always @(negedge clk) rom_q <= rom[rom_addr];
  assign rom_data = rom_CS ? 8'h00 : rom_q;

  typedef struct {
    logic [7:0] op;
    logic [1:0] exp_len;
  } len_vec_t;

  len_vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_instr(input string name, input logic [7:0] op, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [1:0] len, input logic [7:0] pc);
    chk({name, ".valid"}, 32'(instr_valid), 32'd1);
    chk({name, ".opcode"}, 32'(opcode), 32'(op));
    chk({name, ".operand1"}, 32'(operand1), 32'(o1));
    chk({name, ".operand2"}, 32'(operand2), 32'(o2));
    chk({name, ".len"}, 32'(instr_len), 32'(len));
    chk({name, ".instr_pc"}, 32'(instr_pc), 32'(pc));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    if (!instr_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
    end
  endtask

  // Drive jump for exactly one posedge; leaves the DUT in F_OP at return
  task automatic do_jump(input logic [7:0] a);
    @(negedge clk);
    jump_en   = 1'b1;
    jump_addr = a;
    @(negedge clk);
    jump_en   = 1'b0;
  endtask

  // One-cycle handshake pulse from HOLD
  task automatic handshake();
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".valid"}, 32'(instr_valid), 32'd0);
    chk({name, ".rom_CS"}, 32'(rom_CS), 32'd0);
    chk({name, ".rom_addr"}, 32'(rom_addr), 32'h00);
    chk({name, ".opcode"}, 32'(opcode), 32'h00);
    chk({name, ".operand1"}, 32'(operand1), 32'h00);
    chk({name, ".operand2"}, 32'(operand2), 32'h00);
    chk({name, ".len"}, 32'(instr_len), 32'd1);
    chk({name, ".instr_pc"}, 32'(instr_pc), 32'h00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h74; rom[8'h01] = 8'h07; rom[8'h02] = 8'h78; rom[8'h03] = 8'h06;
    rom[8'h0E] = 8'hD4; rom[8'h0F] = 8'h24;
    rom[8'h10] = 8'h75; rom[8'h11] = 8'h30; rom[8'h12] = 8'h0F; rom[8'h13] = 8'h00;
    rom[8'h20] = 8'h05; rom[8'h21] = 8'h90;
    rom[8'hFF] = 8'h74;

    vecs = '{
      '{8'h00, 2'd1}, '{8'h02, 2'd3}, '{8'h12, 2'd3}, '{8'h75, 2'd3}, '{8'h85, 2'd3},
      '{8'h90, 2'd3}, '{8'h05, 2'd2}, '{8'h24, 2'd2}, '{8'h74, 2'd2}, '{8'h76, 2'd2},
      '{8'h78, 2'd2}, '{8'h7F, 2'd2}, '{8'h80, 2'd2}, '{8'h86, 2'd2}, '{8'h88, 2'd2},
      '{8'h8F, 2'd2}, '{8'hA6, 2'd2}, '{8'hAF, 2'd2}, '{8'hE5, 2'd2}, '{8'hF5, 2'd2},
      '{8'h73, 2'd1}, '{8'h84, 2'd1}, '{8'hA5, 2'd1}, '{8'hE4, 2'd1}, '{8'hFF, 2'd1},
      '{8'h03, 2'd1}
    };

    rst_n       = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Sequential fetch from 0x00 with ready held high
    rst_n = 1'b1;
    @(negedge clk);
    chk("seq.cyc1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk_instr("seq.first", 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
    chk("seq.first_cs", 32'(rom_CS), 32'd1);
    @(negedge clk);
    chk("seq.drop_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk_instr("seq.second", 8'h78, 8'h06, 8'h00, 2'd2, 8'h02);
    instr_ready = 1'b0;

    // 3-byte instruction, then the following NOP
    do_jump(8'h10);
    wait_valid("three");
    chk_instr("three", 8'h75, 8'h30, 8'h0F, 2'd3, 8'h10);
    chk("three.rom_addr", 32'(rom_addr), 32'h13);
    handshake();
    wait_valid("three.next");
    chk_instr("three.next", 8'h00, 8'h00, 8'h00, 2'd1, 8'h13);

    // Back-pressure on a 1-byte instruction
    do_jump(8'h0E);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_instr("bp.hold", 8'hD4, 8'h00, 8'h00, 2'd1, 8'h0E);
      chk("bp.rom_CS", 32'(rom_CS), 32'd1);
      chk("bp.rom_addr", 32'(rom_addr), 32'h0F);
    end
    handshake();
    wait_valid("bp.next");
    chk_instr("bp.next", 8'h24, 8'h75, 8'h00, 2'd2, 8'h0F);

    // Jump while in F_B1 of the 3-byte instruction at 0x10
    do_jump(8'h10);
    @(negedge clk);
    chk("midjump.in_b1_addr", 32'(rom_addr), 32'h11);
    chk("midjump.in_b1_valid", 32'(instr_valid), 32'd0);
    jump_en   = 1'b1;
    jump_addr = 8'h20;
    @(negedge clk);
    jump_en = 1'b0;
    wait_valid("midjump");
    chk_instr("midjump", 8'h05, 8'h90, 8'h00, 2'd2, 8'h20);

    // Jump and handshake in the same HOLD cycle: jump wins
    @(negedge clk);
    instr_ready = 1'b1;
    jump_en     = 1'b1;
    jump_addr   = 8'h0E;
    @(negedge clk);
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    wait_valid("jump_hs");
    chk_instr("jump_hs", 8'hD4, 8'h00, 8'h00, 2'd1, 8'h0E);

    // Length table sweep at 0x40
    rom[8'h41] = 8'hA1;
    rom[8'h42] = 8'hB2;
    for (int i = 0; i < 26; i++) begin
      rom[8'h40] = vecs[i].op;
      do_jump(8'h40);
      wait_valid("lentab");
      chk_instr($sformatf("lentab[%02h]", vecs[i].op), vecs[i].op,
                (vecs[i].exp_len >= 2'd2) ? 8'hA1 : 8'h00,
                (vecs[i].exp_len == 2'd3) ? 8'hB2 : 8'h00,
                vecs[i].exp_len, 8'h40);
      chk($sformatf("lentab[%02h].rom_addr", vecs[i].op), 32'(rom_addr),
          32'(8'h40 + 8'(vecs[i].exp_len)));
    end

    // Address wrap mid-instruction
    do_jump(8'hFF);
    wait_valid("wrap");
    chk_instr("wrap", 8'h74, 8'h74, 8'h00, 2'd2, 8'hFF);
    chk("wrap.rom_addr", 32'(rom_addr), 32'h01);
    handshake();
    wait_valid("wrap.next");
    chk_instr("wrap.next", 8'h07, 8'h00, 8'h00, 2'd1, 8'h01);

    // Asynchronous reset during F_B1, then restart from 0x00
    do_jump(8'hFF);
    @(negedge clk);
    chk("rstmid.in_b1_opcode", 32'(opcode), 32'h74);
    chk("rstmid.in_b1_addr", 32'(rom_addr), 32'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.cyc1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk_instr("rstmid.restart", 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
